// File: rtl/ram_fifo_ctrl.sv
// Valid/ready byte FIFO controller wrapping a 16x8 dual-port RAM with registered d_out.
// Push-to-m_valid latency 2 cycles; s_ready drops when full or when a read wins arbitration.
// Optional almost_full/almost_empty outputs under RAM_FIFO_CTRL_ALMOST_EN.
module ram_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int AF_THRESH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] ram_d_in_o,
    output logic [AW-1:0]    ram_wr_addr_o,
    output logic [AW-1:0]    ram_re_addr_o,
    output logic             ram_wr_o,
    output logic             ram_re_o,
    input  logic [WIDTH-1:0] ram_d_out_i,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
`ifdef RAM_FIFO_CTRL_ALMOST_EN
    ,
    output logic             almost_full_o,
    output logic             almost_empty_o
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          m_valid_q, m_valid_d;
    logic          prio_q, prio_d;

    logic wr_elig, rd_elig, grant_wr, grant_rd;

    always_comb begin
        wr_elig  = s_valid_i && (count_q < DEPTH_C);
        rd_elig  = (count_q != '0) && (!m_valid_q || m_ready_i);
        // prio: 0 favours the write side, 1 the read side, only when both compete
        grant_wr = !rst && wr_elig && (!rd_elig || !prio_q);
        grant_rd = !rst && rd_elig && (!wr_elig || prio_q);
    end

    always_comb begin
        wr_ptr_d  = grant_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = grant_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (grant_wr) count_d = count_q + 1'b1;
        if (grant_rd) count_d = count_q - 1'b1;
        m_valid_d = grant_rd ? 1'b1 : (m_ready_i ? 1'b0 : m_valid_q);
        prio_d    = (wr_elig && rd_elig) ? !prio_q : prio_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            prio_q    <= prio_d;
        end
    end

    assign s_ready_o     = !rst && (count_q < DEPTH_C) && !(rd_elig && prio_q);
    assign ram_d_in_o    = s_data_i;
    assign ram_wr_addr_o = wr_ptr_q;
    assign ram_re_addr_o = rd_ptr_q;
    assign ram_wr_o      = grant_wr;
    assign ram_re_o      = grant_rd;
    // The RAM holds d_out until the next re, so the head entry stays stable under stall.
    assign m_data_o      = ram_d_out_i;
    assign m_valid_o     = m_valid_q;
    assign level_o       = count_q + {{AW{1'b0}}, m_valid_q};
    assign full_o        = (count_q == DEPTH_C);
    assign empty_o       = (level_o == '0);

`ifdef RAM_FIFO_CTRL_ALMOST_EN
    assign almost_full_o  = !rst && (level_o >= (AW+1)'(AF_THRESH));
    assign almost_empty_o = rst || (level_o <= (AW+1)'(1));
`else
    // AF_THRESH has no effect without the almost flags.
    if (AF_THRESH < 0) begin : g_af_unused
    end
`endif

endmodule
